// File: rtl/rx_segment_assembler_if.sv
// rx_segment_assembler_if: burst input, frame read port and status bundle for the segment assembler.
// Latency: n/a (wiring only).
// Backpressure: n/a; the upstream burst source has no ready, and overflow is reported through err_ovf.
// Ports: master = burst source / frame consumer side, slave = assembler side.
interface rx_segment_assembler_if #(
    parameter int SEGMENT_NUM_MAX = 5,
    parameter int ADDR_W          = 13
);
    logic                       en_in;
    logic [7:0]                 data_in;
    logic [15:0]                seg_in;
    logic [ADDR_W-1:0]          rd_addr;
    logic [7:0]                 rd_data;
    logic                       frame_ready;
    logic                       rd_release;
    logic                       frame_done;
    logic [SEGMENT_NUM_MAX-1:0] seg_bitmap;
    logic                       err_seg;
    logic                       err_len;
    logic                       err_ovf;
    logic [15:0]                stat_good;
    logic [15:0]                stat_drop;

    modport master (
        output en_in, data_in, seg_in, rd_addr, rd_release,
        input  rd_data, frame_ready, frame_done, seg_bitmap,
        input  err_seg, err_len, err_ovf, stat_good, stat_drop
    );

    modport slave (
        input  en_in, data_in, seg_in, rd_addr, rd_release,
        output rd_data, frame_ready, frame_done, seg_bitmap,
        output err_seg, err_len, err_ovf, stat_good, stat_drop
    );
endinterface

// File: rtl/rx_segment_assembler.sv
// rx_segment_assembler: writes voted segment bursts into a ping-pong frame buffer and hands out completed frames.
// Latency: RAM write 1 cycle after byte capture; rd_data 1 cycle after rd_addr; frame_done 1 cycle after the last bitmap bit sets.
// Backpressure: none towards upstream; with both banks busy, new bursts are dropped (err_ovf) until rd_release.
// Optional: define RX_ASSEMBLER_STATS_EN for stat_good/stat_drop counters (tied to 0 otherwise).
// Ports: clk125MHz, reset (async, active-high), io_bus (slave: en/data/seg burst in, rd_addr/rd_data/rd_release, status pulses).
module rx_segment_assembler #(
    parameter int SEGMENT_NUM_MAX = 5,
    parameter int SEG_BYTES       = 1440,
    parameter int ADDR_W          = 13
) (
    input  logic                  clk125MHz,
    input  logic                  reset,
    rx_segment_assembler_if.slave io_bus
);
    localparam int SEG_W = (SEGMENT_NUM_MAX > 1) ? $clog2(SEGMENT_NUM_MAX) : 1;
    localparam int CNT_W = $clog2(SEG_BYTES + 2);
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEG_BYTES);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(SEG_BYTES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic [1:0]                 r_state;
    logic                       r_wr_bank;
    logic [SEGMENT_NUM_MAX-1:0] r_bitmap;
    logic                       r_frame_ready;
    logic                       r_en_d;
    logic [SEG_W-1:0]           r_seg;
    logic [ADDR_W-1:0]          r_base;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_we;
    logic [ADDR_W:0]            r_waddr;
    logic [7:0]                 r_wdat;
    logic [7:0]                 r_rd_data;
    logic                       r_frame_done;
    logic                       r_err_seg;
    logic                       r_err_len;
    logic                       r_err_ovf;
    logic [7:0]                 r_mem [0:DEPTH-1];

    logic [1:0]                 w_state_nxt;
    logic                       w_bank_nxt;
    logic [SEGMENT_NUM_MAX-1:0] w_bitmap_nxt;
    logic                       w_ready_nxt;
    logic [SEG_W-1:0]           w_seg_nxt;
    logic [ADDR_W-1:0]          w_base_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_we_nxt;
    logic [ADDR_W:0]            w_waddr_nxt;
    logic [7:0]                 w_wdat_nxt;
    logic                       w_done_nxt;
    logic                       w_err_seg_nxt;
    logic                       w_err_len_nxt;
    logic                       w_err_ovf_nxt;

    logic                       w_rise;
    logic                       w_release;
    logic                       w_complete;
    logic                       w_seg_ok;
    logic [ADDR_W-1:0]          w_base_new;
    logic [ADDR_W-1:0]          w_wr_off;
    logic [SEGMENT_NUM_MAX-1:0] w_seg_mask;

    assign w_rise     = io_bus.en_in & ~r_en_d;
    assign w_release  = io_bus.rd_release & r_frame_ready;
    assign w_complete = &r_bitmap;
    assign w_seg_ok   = (32'(io_bus.seg_in) < 32'(SEGMENT_NUM_MAX));
    assign w_base_new = ADDR_W'(32'(io_bus.seg_in) * 32'(SEG_BYTES));
    assign w_wr_off   = r_base + ADDR_W'(r_cnt);
    assign w_seg_mask = SEGMENT_NUM_MAX'(1) << r_seg;

    always_comb begin
        w_state_nxt   = r_state;
        w_bank_nxt    = r_wr_bank;
        w_bitmap_nxt  = r_bitmap;
        w_ready_nxt   = r_frame_ready;
        w_seg_nxt     = r_seg;
        w_base_nxt    = r_base;
        w_cnt_nxt     = r_cnt;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdat_nxt    = r_wdat;
        w_done_nxt    = 1'b0;
        w_err_seg_nxt = 1'b0;
        w_err_len_nxt = 1'b0;
        w_err_ovf_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Release is applied before the completion test so a frame that
                // completes in the release cycle swaps straight in.
                if (w_release) w_ready_nxt = 1'b0;
                if (w_complete) begin
                    if (!w_ready_nxt) begin
                        w_bank_nxt   = ~r_wr_bank;
                        w_bitmap_nxt = '0;
                        w_ready_nxt  = 1'b1;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_state_nxt  = S_FULL;
                    end
                end
                if (w_rise) begin
                    if (w_state_nxt == S_FULL) begin
                        // Burst starting as we enter FULL: FULL swallows its bytes.
                        w_err_ovf_nxt = 1'b1;
                    end else if (!w_seg_ok) begin
                        w_err_seg_nxt = 1'b1;
                        w_state_nxt   = S_DROP;
                    end else begin
                        w_seg_nxt   = SEG_W'(io_bus.seg_in);
                        w_base_nxt  = w_base_new;
                        w_cnt_nxt   = CNT_W'(1);
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = {w_bank_nxt, w_base_new};
                        w_wdat_nxt  = io_bus.data_in;
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (w_release) w_ready_nxt = 1'b0;
                if (io_bus.en_in) begin
                    if (r_cnt < CNT_FULL) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = {r_wr_bank, w_wr_off};
                        w_wdat_nxt  = io_bus.data_in;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end else begin
                        // Excess bytes are discarded; the saturated count marks the burst long.
                        w_cnt_nxt   = CNT_OVER;
                    end
                end else begin
                    if (r_cnt == CNT_FULL) w_bitmap_nxt  = r_bitmap | w_seg_mask;
                    else                   w_err_len_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (w_release) w_ready_nxt = 1'b0;
                if (!io_bus.en_in) w_state_nxt = S_IDLE;
            end
            S_FULL: begin
                if (w_rise) w_err_ovf_nxt = 1'b1;
                if (io_bus.rd_release) begin
                    // Write bank becomes the read bank; frame_ready stays high.
                    w_bank_nxt   = ~r_wr_bank;
                    w_bitmap_nxt = '0;
                    w_done_nxt   = 1'b1;
                    // A burst in flight keeps being dropped until it ends.
                    w_state_nxt  = io_bus.en_in ? S_DROP : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_bank     <= 1'b0;
            r_bitmap      <= '0;
            r_frame_ready <= 1'b0;
            r_en_d        <= 1'b0;
            r_seg         <= '0;
            r_base        <= '0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdat        <= '0;
            r_frame_done  <= 1'b0;
            r_err_seg     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_bank     <= w_bank_nxt;
            r_bitmap      <= w_bitmap_nxt;
            r_frame_ready <= w_ready_nxt;
            r_en_d        <= io_bus.en_in;
            r_seg         <= w_seg_nxt;
            r_base        <= w_base_nxt;
            r_cnt         <= w_cnt_nxt;
            r_we          <= w_we_nxt;
            r_waddr       <= w_waddr_nxt;
            r_wdat        <= w_wdat_nxt;
            r_frame_done  <= w_done_nxt;
            r_err_seg     <= w_err_seg_nxt;
            r_err_len     <= w_err_len_nxt;
            r_err_ovf     <= w_err_ovf_nxt;
        end
    end

    // Simple dual-port RAM: no reset on the array so it maps onto block RAM.
    always_ff @(posedge clk125MHz) begin
        if (r_we) r_mem[r_waddr] <= r_wdat;
    end

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) r_rd_data <= '0;
        else       r_rd_data <= r_mem[{~r_wr_bank, io_bus.rd_addr}];
    end

    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.frame_ready = r_frame_ready;
    assign io_bus.frame_done  = r_frame_done;
    assign io_bus.seg_bitmap  = r_bitmap;
    assign io_bus.err_seg     = r_err_seg;
    assign io_bus.err_len     = r_err_len;
    assign io_bus.err_ovf     = r_err_ovf;

`ifdef RX_ASSEMBLER_STATS_EN
    logic [15:0] r_stat_good;
    logic [15:0] r_stat_drop;
    logic        w_good_evt;
    logic        w_drop_evt;

    assign w_good_evt = (r_state == S_WRITE) && !io_bus.en_in && (r_cnt == CNT_FULL);
    assign w_drop_evt = w_err_seg_nxt | w_err_len_nxt | w_err_ovf_nxt;

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            r_stat_good <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_good_evt) r_stat_good <= r_stat_good + 16'd1;
            if (w_drop_evt) r_stat_drop <= r_stat_drop + 16'd1;
        end
    end

    assign io_bus.stat_good = r_stat_good;
    assign io_bus.stat_drop = r_stat_drop;
`else
    assign io_bus.stat_good = '0;
    assign io_bus.stat_drop = '0;
`endif
endmodule

// File: tb/tb_rx_segment_assembler.sv
// tb_rx_segment_assembler: scoreboard bench for rx_segment_assembler with 3 segments of 4 bytes.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_segment_assembler;
    localparam logic [3:0] EV_SEG  = 4'b0001;
    localparam logic [3:0] EV_LEN  = 4'b0010;
    localparam logic [3:0] EV_OVF  = 4'b0100;
    localparam logic [3:0] EV_DONE = 4'b1000;
    localparam logic [3:0] EV_NONE = 4'b0000;

    logic clk;
    logic reset;
    logic rd_act;
    logic rd_act_d;
    int   n_checks;
    int   n_errors;

    logic [3:0] q_evt [$];
    logic [7:0] q_rd  [$];
    logic [3:0] w_evt;

    rx_segment_assembler_if #(.SEGMENT_NUM_MAX(3), .ADDR_W(4)) bus ();

    rx_segment_assembler #(
        .SEGMENT_NUM_MAX(3),
        .SEG_BYTES      (4),
        .ADDR_W         (4)
    ) dut (
        .clk125MHz(clk),
        .reset    (reset),
        .io_bus   (bus)
    );

    always #4 clk = ~clk;

    assign w_evt = {bus.frame_done, bus.err_ovf, bus.err_len, bus.err_seg};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulses are popped against the expected-event queue as they appear.
    always @(negedge clk) begin
        if (!reset && w_evt != 4'b0000) begin
            if (q_evt.size() == 0) check_val("evt_unexpected", w_evt, 4'b0000);
            else                   check_val("evt", w_evt, q_evt.pop_front());
        end
    end

    // Read data appears one cycle after the address was presented.
    always @(posedge clk) rd_act_d <= rd_act;

    always @(negedge clk) begin
        if (rd_act_d) begin
            if (q_rd.size() == 0) check_val("rd_unexpected", q_rd.size(), 1);
            else                  check_val("rd_data", bus.rd_data, q_rd.pop_front());
        end
    end

    task automatic send_burst(input logic [15:0] seg, input int n, input logic [7:0] d0,
                              input logic [3:0] ev, input logic [2:0] exp_bm);
        if (ev != EV_NONE) q_evt.push_back(ev);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.en_in   = 1'b1;
            bus.seg_in  = seg;
            bus.data_in = d0 + 8'(i);
        end
        @(posedge clk); #1;
        bus.en_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("bitmap", bus.seg_bitmap, exp_bm);
        repeat (3) @(posedge clk);
    endtask

    task automatic read_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bases [3];
        bases[0] = b0;
        bases[1] = b1;
        bases[2] = b2;
        for (int a = 0; a < 12; a++) begin
            @(posedge clk); #1;
            bus.rd_addr = 4'(a);
            rd_act      = 1'b1;
            q_rd.push_back(bases[a / 4] + 8'(a % 4));
        end
        @(posedge clk); #1;
        rd_act = 1'b0;
        repeat (2) @(posedge clk);
        check_val("rd_drain", q_rd.size(), 0);
    endtask

    task automatic release_bank(input logic [3:0] ev);
        if (ev != EV_NONE) q_evt.push_back(ev);
        @(posedge clk); #1;
        bus.rd_release = 1'b1;
        @(posedge clk); #1;
        bus.rd_release = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic evq_drained(input string tag);
        check_val(tag, q_evt.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        rd_act         = 1'b0;
        n_checks       = 0;
        n_errors       = 0;
        bus.en_in      = 1'b0;
        bus.data_in    = 8'h00;
        bus.seg_in     = 16'h0000;
        bus.rd_addr    = 4'h0;
        bus.rd_release = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_ready",  bus.frame_ready, 0);
        check_val("rst_bitmap", bus.seg_bitmap, 0);
        check_val("rst_rdata",  bus.rd_data, 0);
        check_val("rst_pulses", w_evt, 0);
        check_val("rst_sgood",  bus.stat_good, 0);
        check_val("rst_sdrop",  bus.stat_drop, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // In-order reassembly
        send_burst(16'd0, 4, 8'h00, EV_NONE, 3'b001);
        send_burst(16'd1, 4, 8'h10, EV_NONE, 3'b011);
        send_burst(16'd2, 4, 8'h20, EV_DONE, 3'b111);
        check_val("t1_ready", bus.frame_ready, 1);
        check_val("t1_bm_clr", bus.seg_bitmap, 0);
        read_frame(8'h00, 8'h10, 8'h20);
        release_bank(EV_NONE);
        check_val("t1_released", bus.frame_ready, 0);
        evq_drained("t1_evq");

        // Out-of-order with a duplicate
        send_burst(16'd2, 4, 8'h20, EV_NONE, 3'b100);
        send_burst(16'd0, 4, 8'h00, EV_NONE, 3'b101);
        send_burst(16'd2, 4, 8'hA0, EV_NONE, 3'b101);
        send_burst(16'd1, 4, 8'h10, EV_DONE, 3'b111);
        check_val("t2_ready", bus.frame_ready, 1);
        read_frame(8'h00, 8'h10, 8'hA0);
        release_bank(EV_NONE);
        evq_drained("t2_evq");

        // Length errors and bad indices
        send_burst(16'd1, 3, 8'h30, EV_LEN, 3'b000);
        send_burst(16'd1, 6, 8'h40, EV_LEN, 3'b000);
        send_burst(16'd0, 4, 8'h50, EV_NONE, 3'b001);
        send_burst(16'd1, 4, 8'h60, EV_NONE, 3'b011);
        send_burst(16'd1, 6, 8'h70, EV_LEN, 3'b011);
        send_burst(16'd3, 4, 8'hEE, EV_SEG, 3'b011);
        send_burst(16'hFFFF, 4, 8'hEE, EV_SEG, 3'b011);
        check_val("t3_not_ready", bus.frame_ready, 0);
        send_burst(16'd2, 4, 8'h80, EV_DONE, 3'b111);
        read_frame(8'h50, 8'h70, 8'h80);
        release_bank(EV_NONE);
        evq_drained("t3_evq");

        // Second frame completes while the first is still held
        send_burst(16'd0, 4, 8'h90, EV_NONE, 3'b001);
        send_burst(16'd1, 4, 8'h94, EV_NONE, 3'b011);
        send_burst(16'd2, 4, 8'h98, EV_DONE, 3'b111);
        send_burst(16'd0, 4, 8'hC0, EV_NONE, 3'b001);
        send_burst(16'd1, 4, 8'hC4, EV_NONE, 3'b011);
        send_burst(16'd2, 4, 8'hC8, EV_NONE, 3'b111);
        check_val("t5_full_bm", bus.seg_bitmap, 3'b111);
        check_val("t5_full_ready", bus.frame_ready, 1);
        send_burst(16'd0, 4, 8'hEE, EV_OVF, 3'b111);
        read_frame(8'h90, 8'h94, 8'h98);
        release_bank(EV_DONE);
        check_val("t5_ready_kept", bus.frame_ready, 1);
        check_val("t5_bm_clr", bus.seg_bitmap, 0);
        read_frame(8'hC0, 8'hC4, 8'hC8);
        evq_drained("t5_evq");

        // Async reset in the middle of a burst
        send_burst(16'd0, 4, 8'hD0, EV_NONE, 3'b001);
        @(posedge clk); #1;
        bus.en_in   = 1'b1;
        bus.seg_in  = 16'd1;
        bus.data_in = 8'hD4;
        @(posedge clk); #1;
        bus.data_in = 8'hD5;
        #1;
        reset = 1'b1;
        #1;
        check_val("ar_ready",  bus.frame_ready, 0);
        check_val("ar_bitmap", bus.seg_bitmap, 0);
        check_val("ar_rdata",  bus.rd_data, 0);
        check_val("ar_pulses", w_evt, 0);
        @(posedge clk); #1;
        bus.en_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        send_burst(16'd0, 4, 8'hE0, EV_NONE, 3'b001);
        send_burst(16'd3, 4, 8'hEE, EV_SEG, 3'b001);
`ifdef RX_ASSEMBLER_STATS_EN
        check_val("stat_good", bus.stat_good, 1);
        check_val("stat_drop", bus.stat_drop, 1);
`else
        check_val("stat_good", bus.stat_good, 0);
        check_val("stat_drop", bus.stat_drop, 0);
`endif
        evq_drained("t6_evq");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx_segment_assembler.md
Name: rx_segment_assembler

Overview:
- Sits directly downstream of the RX majority/segment-dispatch stage.
- Consumes its voted byte bursts (en/data plus segment index) and writes each segment's payload into a ping-pong frame buffer at offset seg*SEG_BYTES.
- Tracks received segments in a bitmap and flags frame completion.
- Exposes the completed bank through a synchronous read port for the display/consumer logic.

Parameters:
- SEGMENT_NUM_MAX, 5, segments per frame; must match the upstream dispatcher.
- SEG_BYTES, 1440, payload bytes per segment burst.
- ADDR_W, 13, read/write address width; must satisfy 2^ADDR_W >= SEGMENT_NUM_MAX*SEG_BYTES.

Ports:
- clk125MHz, input, 1: sole clock.
- reset, input, 1: asynchronous, active-high reset.
- en_in, input, 1: burst valid, high for every byte of one segment.
- data_in, input, 8: payload byte.
- seg_in, input, 16: segment index; valid on every cycle en_in is high.
- rd_addr, input, ADDR_W: read address within the ready bank.
- rd_data, output, 8: registered read data.
- frame_ready, output, 1: read bank holds a complete frame.
- rd_release, input, 1: single-cycle pulse; consumer has finished with the read bank.
- frame_done, output, 1: one-cycle pulse when a bank swap occurs.
- seg_bitmap, output, SEGMENT_NUM_MAX: segments received in the current write bank.
- err_seg, output, 1: one-cycle pulse; burst dropped because seg_in >= SEGMENT_NUM_MAX.
- err_len, output, 1: one-cycle pulse; burst length != SEG_BYTES.
- err_ovf, output, 1: one-cycle pulse; burst dropped because the write bank is full and the read bank is busy.
- stat_good, output, 16: count of good segments (optional feature).
- stat_drop, output, 16: count of dropped bursts (optional feature).

Behaviour:
- Reset (async): state IDLE, wr_bank=0, bitmap=0, frame_ready=0, all pulses 0, rd_data=0, stats=0.
- Memory: 2*2^ADDR_W bytes, inferred as simple dual-port RAM. Write address is {wr_bank, addr}; read address is {~wr_bank, rd_addr}.
- rd_data latency: 1 cycle. Data is undefined when frame_ready=0.
- Write FSM states: IDLE, WRITE, DROP, FULL.
- IDLE, on en_in rising (en_in=1 and the previous en_in=0):
  - seg_in >= SEGMENT_NUM_MAX -> DROP and pulse err_seg.
  - Otherwise latch seg, base = seg*SEG_BYTES (constant multiply), cnt=0 -> WRITE.
  - The first byte is captured in the same cycle.
- WRITE:
  - Each cycle with en_in=1 and cnt < SEG_BYTES: write data_in to base+cnt (write registered one cycle later), cnt++.
  - Bytes beyond SEG_BYTES are discarded; cnt saturates at SEG_BYTES+1.
  - On en_in=0: if cnt==SEG_BYTES, set bitmap[seg]; otherwise pulse err_len and leave the bit unchanged. Return to IDLE.
  - Bytes already written by a short or long burst stay in memory.
- Duplicate segment: payload is overwritten and the bitmap bit stays set.
- DROP: ignore bytes until en_in=0, then go to IDLE.
- Completion is evaluated the cycle after the bitmap updates, when all bits are set:
  - If frame_ready=0: swap banks (wr_bank toggles), bitmap cleared, frame_ready=1, frame_done pulse.
  - Otherwise go to FULL.
- FULL:
  - Every new burst is dropped: pulse err_ovf once per burst and consume it as in DROP.
  - On rd_release: swap, frame_done pulse, frame_ready stays 1, return to IDLE.
  - If a burst is in progress when release arrives, the swap still happens. That burst continues to be dropped, and the FSM returns to IDLE at its end.
- rd_release with frame_ready=1 and not FULL: frame_ready goes to 0 next cycle.
- rd_release with frame_ready=0: ignored.
- Simultaneous completion and rd_release in the same cycle: release is processed first, then the swap happens, so frame_ready remains 1.
- en_in must have at least 1 idle cycle between bursts. This is guaranteed by the upstream stage.
- Reset mid-burst: the burst is lost; memory contents are not cleared.

Optional Feature:
- Macro: RX_ASSEMBLER_STATS_EN.
- When defined:
  - stat_good increments on each bitmap set event, including duplicates.
  - stat_drop increments on each err_seg, err_len or err_ovf pulse.
  - Both counters are 16-bit and wrap 0xFFFF -> 0.
  - Both are cleared by reset.
- When undefined: both ports are tied to 0 and no counter logic exists.

Test Plan (bench overrides SEGMENT_NUM_MAX=3, SEG_BYTES=4):
- Reassembly: bursts seg0 {00..03}, seg1 {10..13}, seg2 {20..23} -> bitmap 001,011,111; frame_done pulse; frame_ready=1; reads at addr 0..11 return 00..03,10..13,20..23, one cycle after each address.
- Out-of-order and duplicate: seg2, seg0, seg2 {A0..A3}, seg1 -> one frame_done; addr 8..11 read A0..A3.
- Length errors: seg1 with 3 bytes -> err_len, bitmap bit1=0. seg1 with 6 bytes -> err_len, addr 4..7 hold the first 4 bytes, bit1 stays 0.
- Bad index: seg_in=3 -> err_seg, no writes, bitmap unchanged.
- Backpressure: second full frame completes while frame_ready=1 -> FULL; extra burst gives err_ovf; rd_release -> frame_done, read bank now shows the second frame.
- Async reset asserted mid-burst -> outputs 0 immediately, FSM IDLE; with RX_ASSEMBLER_STATS_EN, after one good and one err_seg burst stat_good=1, stat_drop=1.
